// File: rtl/alu_command_sequencer.sv
// ---------------------------------------------------------------------------
// alu_command_sequencer
//
// Command stage that sits in front of the ArithmeticLogicUnit. One command
// (function code, two operands, repeat count, flag-write enable) is accepted
// over a valid/ready handshake. The sequencer then drives the ALU inputs for
// CmdRepeat+1 iterations. After each iteration the ALU result is fed back into
// operand A. The final result and the ALU flags are captured into a response.
// The response is held until the consumer takes it.
//
// Optional feature (compile-time macro ALU_SEQ_ZERO_EXIT_EN):
//   When defined, an iteration whose ALU result is zero ends the repeat loop
//   early. When undefined, every requested iteration always runs.
//
// Ports:
//   Clock        system clock, rising edge
//   Reset        asynchronous active-low reset
//   CmdValid     command present
//   CmdReady     sequencer can accept a command (idle only)
//   CmdFunSel    ALU function code for the command
//   CmdA         first operand (seed value for the feedback loop)
//   CmdB         second operand, constant across iterations
//   CmdRepeat    number of extra iterations (0 = single operation)
//   CmdSetFlags  1 = let the ALU update its flags on every iteration
//   A, B         operand outputs to the ALU
//   FunSel       function code output to the ALU
//   WF           flag write enable to the ALU
//   ALUOut       combinational ALU result
//   FlagsOut     registered ALU flags {Z,C,N,O}
//   RspValid     response is being held
//   RspReady     consumer accepts the response
//   RspData      final ALU result
//   RspFlags     ALU flags sampled after the final iteration
//   Busy         sequencer is doing anything other than waiting for a command
// ---------------------------------------------------------------------------
module alu_command_sequencer #(
   parameter int REPEAT_W = 5
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                CmdValid,
   output logic                CmdReady,
   input  logic [4:0]          CmdFunSel,
   input  logic [31:0]         CmdA,
   input  logic [31:0]         CmdB,
   input  logic [REPEAT_W-1:0] CmdRepeat,
   input  logic                CmdSetFlags,
   output logic [31:0]         A,
   output logic [31:0]         B,
   output logic [4:0]          FunSel,
   output logic                WF,
   input  logic [31:0]         ALUOut,
   input  logic [3:0]          FlagsOut,
   output logic                RspValid,
   input  logic                RspReady,
   output logic [31:0]         RspData,
   output logic [3:0]          RspFlags,
   output logic                Busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } stateT;

   stateT                state;
   logic [REPEAT_W-1:0]  count;
   logic                 setFlags;
   logic                 zeroExit;

   // The early-exit condition is a compile-time choice. With the feature off,
   // the loop length depends only on the latched repeat count.
`ifdef ALU_SEQ_ZERO_EXIT_EN
   assign zeroExit = (ALUOut == 32'd0);
`else
   assign zeroExit = 1'b0;
`endif

   // WF is decoded from the state register rather than registered. This lets
   // it follow the ALU iteration it belongs to. An asynchronous reset forces
   // IDLE, so WF drops immediately whenever reset is asserted.
   assign WF = (state == ISSUE) && setFlags;

   // Main sequencer. The counter is tested for zero before it is decremented.
   // Because of this, an all-ones repeat value gives exactly 2**REPEAT_W
   // iterations and the counter never wraps. CmdReady, Busy and RspValid are
   // registered alongside each state change, so they always agree with the
   // state the FSM has just entered.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         A        <= '0;
         B        <= '0;
         FunSel   <= '0;
         RspData  <= '0;
         RspFlags <= '0;
         count    <= '0;
         setFlags <= 1'b0;
         CmdReady <= 1'b1;
         Busy     <= 1'b0;
         RspValid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (CmdValid) begin
                  FunSel   <= CmdFunSel;
                  A        <= CmdA;
                  B        <= CmdB;
                  count    <= CmdRepeat;
                  setFlags <= CmdSetFlags;
                  state    <= ISSUE;
                  CmdReady <= 1'b0;
                  Busy     <= 1'b1;
               end
            end
            ISSUE: begin
               RspData <= ALUOut;
               A       <= ALUOut;
               if ((count == '0) || zeroExit) begin
                  state <= CAPTURE;
               end else begin
                  count <= count - REPEAT_W'(1);
               end
            end
            CAPTURE: begin
               RspFlags <= FlagsOut;
               RspValid <= 1'b1;
               state    <= RESP;
            end
            RESP: begin
               if (RspReady) begin
                  RspValid <= 1'b0;
                  Busy     <= 1'b0;
                  CmdReady <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_command_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_command_sequencer
//
// Bench for alu_command_sequencer. A small ALU model forms the environment:
// ADD, ADC, SUB, LSL by one, and AND as the default. It has a combinational
// result and flags {Z,C,N,O} that are written on the clock when WF is high.
// Expected responses come from a reference loop. The loop applies the ALU
// rule CmdRepeat+1 times and tracks the flags the ALU should hold between
// commands.
// Honours ALU_SEQ_ZERO_EXIT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_alu_command_sequencer;

   localparam int REPEAT_W = 5;
   localparam logic [4:0] OP_AND = 5'b00000;
   localparam logic [4:0] OP_ADD = 5'b10100;
   localparam logic [4:0] OP_ADC = 5'b10101;
   localparam logic [4:0] OP_SUB = 5'b10110;
   localparam logic [4:0] OP_LSL = 5'b11011;

   logic                Clock = 1'b0;
   logic                Reset = 1'b0;
   logic                CmdValid = 1'b0;
   logic                CmdReady;
   logic [4:0]          CmdFunSel = '0;
   logic [31:0]         CmdA = '0;
   logic [31:0]         CmdB = '0;
   logic [REPEAT_W-1:0] CmdRepeat = '0;
   logic                CmdSetFlags = 1'b0;
   logic [31:0]         A;
   logic [31:0]         B;
   logic [4:0]          FunSel;
   logic                WF;
   logic [31:0]         ALUOut;
   logic [3:0]          FlagsOut;
   logic                RspValid;
   logic                RspReady = 1'b0;
   logic [31:0]         RspData;
   logic [3:0]          RspFlags;
   logic                Busy;

   int          compared = 0;
   int          mismatched = 0;
   int          cycleCnt = 0;
   int          acceptCycle = 0;
   logic [3:0]  modelFlags = 4'b0000;
   logic [3:0]  flagsReg = 4'b0000;
   logic [35:0] aluNow;

   alu_command_sequencer #(.REPEAT_W(REPEAT_W)) dut (
      .Clock(Clock), .Reset(Reset),
      .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdFunSel(CmdFunSel),
      .CmdA(CmdA), .CmdB(CmdB), .CmdRepeat(CmdRepeat), .CmdSetFlags(CmdSetFlags),
      .A(A), .B(B), .FunSel(FunSel), .WF(WF),
      .ALUOut(ALUOut), .FlagsOut(FlagsOut),
      .RspValid(RspValid), .RspReady(RspReady),
      .RspData(RspData), .RspFlags(RspFlags), .Busy(Busy)
   );

   // Free-running clock and cycle counter used for throughput measurement
   always #5 Clock = ~Clock;

   always @(posedge Clock) cycleCnt <= cycleCnt + 1;

   // ALU behaviour: returns {Z,C,N,O,result}
   function automatic logic [35:0] aluEval(input logic [4:0] fun, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
      logic [32:0] wide;
      logic [31:0] r;
      logic        c;
      logic        o;
      c = 1'b0;
      o = 1'b0;
      case (fun)
         OP_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            r = wide[31:0];
            c = wide[32];
            o = (a[31] == b[31]) && (r[31] != a[31]);
         end
         OP_ADC: begin
            wide = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            r = wide[31:0];
            c = wide[32];
            o = (a[31] == b[31]) && (r[31] != a[31]);
         end
         OP_SUB: begin
            r = a - b;
            c = (a >= b);
            o = (a[31] != b[31]) && (r[31] != a[31]);
         end
         OP_LSL: begin
            r = a << 1;
            c = a[31];
         end
         default: r = a & b;
      endcase
      return {(r == 32'd0), c, r[31], o, r};
   endfunction

   // ALU environment driven by the sequencer outputs
   assign aluNow   = aluEval(FunSel, A, B, flagsReg[2]);
   assign ALUOut   = aluNow[31:0];
   assign FlagsOut = flagsReg;

   always @(posedge Clock) if (WF) flagsReg <= aluNow[35:32];

   // Reference: run up to maxIters ALU steps with result feedback
   function automatic void refRun(input logic [4:0] fun, input logic [31:0] a, input logic [31:0] b,
                                  input int maxIters, input logic setf, inout logic [3:0] flags,
                                  output logic [31:0] data, output int iters);
      logic [31:0] acc;
      logic [35:0] res;
      acc = a;
      iters = 0;
      for (int i = 0; i < maxIters; i++) begin
         res = aluEval(fun, acc, b, flags[2]);
         acc = res[31:0];
         if (setf) flags = res[35:32];
         iters++;
`ifdef ALU_SEQ_ZERO_EXIT_EN
         if (acc == 32'd0) break;
`endif
      end
      data = acc;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one full command and checks it. Enters and leaves on a falling edge.
   task automatic applyStimulus(input logic [4:0] fun, input logic [31:0] a, input logic [31:0] b,
                                input logic [REPEAT_W-1:0] rep, input logic setf,
                                input int hold, input logic earlyReady);
      logic [31:0] expData;
      logic [3:0]  expFlags;
      int          iters;
      int          lat;
      int          wfCnt;
      int          n;
      n = 0;
      while (!CmdReady && n < 50) begin
         @(negedge Clock);
         n++;
      end
      checkOutput("cmdReadyIdle", CmdReady, 1);
      expFlags = modelFlags;
      refRun(fun, a, b, int'(rep) + 1, setf, expFlags, expData, iters);
      CmdValid = 1'b1;
      CmdFunSel = fun;
      CmdA = a;
      CmdB = b;
      CmdRepeat = rep;
      CmdSetFlags = setf;
      @(posedge Clock);
      @(negedge Clock);
      acceptCycle = cycleCnt;
      CmdValid = 1'b0;
      CmdA = $urandom;
      CmdB = $urandom;
      if (hold == 0 && earlyReady) RspReady = 1'b1;
      checkOutput("busyAfterAccept", Busy, 1);
      checkOutput("cmdReadyBusy", CmdReady, 0);
      lat = 0;
      wfCnt = 0;
      while (!RspValid && lat < 100) begin
         if (WF) wfCnt++;
         @(posedge Clock);
         lat++;
         @(negedge Clock);
      end
      checkOutput("latency", lat, iters + 1);
      checkOutput("wfCycles", wfCnt, setf ? iters : 0);
      checkOutput("rspData", RspData, expData);
      checkOutput("rspFlags", RspFlags, expFlags);
      checkOutput("funSelOut", FunSel, fun);
      checkOutput("bOut", B, b);
      checkOutput("aFeedback", A, expData);
      checkOutput("wfInResp", WF, 0);
      checkOutput("cmdReadyResp", CmdReady, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge Clock);
         @(negedge Clock);
         checkOutput("holdValid", RspValid, 1);
         checkOutput("holdData", RspData, expData);
         checkOutput("holdFlags", RspFlags, expFlags);
         checkOutput("holdCmdReady", CmdReady, 0);
         checkOutput("holdWf", WF, 0);
      end
      RspReady = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      RspReady = 1'b0;
      checkOutput("rspDropped", RspValid, 0);
      checkOutput("idleCmdReady", CmdReady, 1);
      checkOutput("idleBusy", Busy, 0);
      modelFlags = expFlags;
   endtask

   // Hard stop in case something hangs outside the bounded waits
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed steps followed by a randomized run
   initial begin
      logic [4:0]  ops [5];
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] junk;
      logic [4:0]  fun;
      int          firstAccept;
      int          iters;
      int          spurious;
      ops[0] = OP_AND; ops[1] = OP_ADD; ops[2] = OP_ADC; ops[3] = OP_SUB; ops[4] = OP_LSL;

      repeat (2) @(negedge Clock);
      checkOutput("resetWf", WF, 0);
      checkOutput("resetRspValid", RspValid, 0);
      checkOutput("resetBusy", Busy, 0);
      Reset = 1'b1;
      @(negedge Clock);
      checkOutput("relCmdReady", CmdReady, 1);
      checkOutput("relA", A, 0);
      checkOutput("relB", B, 0);
      checkOutput("relFunSel", FunSel, 0);
      checkOutput("relRspData", RspData, 0);
      checkOutput("relRspFlags", RspFlags, 0);

      applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1, 2, 1'b0);
      applyStimulus(OP_LSL, 32'd1, 32'd0, 5'd3, 1'b1, 0, 1'b0);
      applyStimulus(OP_ADD, 32'h1234_5678, 32'h1111_1111, 5'd2, 1'b1, 10, 1'b0);
      applyStimulus(OP_LSL, 32'h8000_0000, 32'd0, 5'd7, 1'b1, 0, 1'b0);
      applyStimulus(OP_SUB, 32'd5, 32'd5, 5'd0, 1'b0, 1, 1'b0);
      applyStimulus(OP_ADD, 32'd0, 32'd1, 5'd31, 1'b1, 0, 1'b0);
      applyStimulus(OP_ADC, 32'hFFFF_FFF0, 32'd8, 5'd4, 1'b1, 0, 1'b1);

      applyStimulus(OP_AND, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd2, 1'b0, 0, 1'b0);
      firstAccept = acceptCycle;
      applyStimulus(OP_ADD, 32'd3, 32'd4, 5'd4, 1'b0, 0, 1'b0);
      checkOutput("throughput", acceptCycle - firstAccept, 6);

      // Abort a long command after two flag-writing iterations
      CmdValid = 1'b1;
      CmdFunSel = OP_AND;
      CmdA = 32'hF0F0_F0F0;
      CmdB = 32'hFFFF_FFFF;
      CmdRepeat = 5'd7;
      CmdSetFlags = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      CmdValid = 1'b0;
      repeat (2) begin
         @(posedge Clock);
         @(negedge Clock);
      end
      checkOutput("wfBeforeReset", WF, 1);
      refRun(OP_AND, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 2, 1'b1, modelFlags, junk, iters);
      Reset = 1'b0;
      #1;
      checkOutput("abortWf", WF, 0);
      checkOutput("abortA", A, 0);
      checkOutput("abortB", B, 0);
      checkOutput("abortFunSel", FunSel, 0);
      checkOutput("abortRspData", RspData, 0);
      checkOutput("abortRspValid", RspValid, 0);
      checkOutput("abortBusy", Busy, 0);
      @(negedge Clock);
      Reset = 1'b1;
      spurious = 0;
      repeat (6) begin
         @(negedge Clock);
         if (RspValid) spurious++;
      end
      checkOutput("noRspAfterAbort", spurious, 0);
      checkOutput("abortFlagsKept", FlagsOut, modelFlags);
      applyStimulus(OP_SUB, 32'd100, 32'd7, 5'd1, 1'b1, 1, 1'b0);

      for (int i = 0; i < 25; i++) begin
         fun = ops[$urandom_range(0, 4)];
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = ra;
         if ($urandom_range(0, 5) == 0) ra = 32'd0;
         applyStimulus(fun, ra, rb, 5'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
